// File: rtl/bsg_share_array32_if.sv
// Operand load, counter input and unary output bundle
// for the shared-counter unary stream generator.
interface bsg_share_array32_if #(
   parameter int CWID = 10,
   parameter int SDIM = 32
);
   logic                       enable;
   logic [SDIM-1:0][CWID-1:0]  cntSeq;
   logic                       inValid;
   logic                       inReady;
   logic [SDIM-1:0][CWID-1:0]  inData;
   logic [SDIM-1:0]            bitOut;
   logic                       bitValid;
   logic                       winStart;
   logic                       winDone;

   modport master (
      output enable, cntSeq, inValid, inData,
      input  inReady, bitOut, bitValid, winStart, winDone
   );

   modport slave (
      input  enable, cntSeq, inValid, inData,
      output inReady, bitOut, bitValid, winStart, winDone
   );
endinterface

// File: rtl/bsg_share_array32.sv
// Binary-to-unary lane array: each held operand is compared
// against its lane of a shared counter, one bit per enabled cycle.
module bsg_share_array32 #(
   parameter int CWID = 10,
   parameter int SDIM = 32,
   parameter int WLEN = 2**CWID
) (
   input logic                 clk,
   input logic                 rst_n,
   bsg_share_array32_if.slave  bus
);
   localparam int WW = (WLEN > 1) ? $clog2(WLEN) : 1;
   localparam logic [WW-1:0] LAST = WW'(WLEN - 1);

   typedef enum logic {IDLE, RUN} state_e;

   state_e                     state_q, state_d;
   logic [SDIM-1:0][CWID-1:0]  shadow_q, shadow_d;
   logic [SDIM-1:0][CWID-1:0]  active_q, active_d;
   logic                       shadow_full_q, shadow_full_d;
   logic [WW-1:0]              win_cnt_q, win_cnt_d;
   logic [SDIM-1:0]            bit_out_q, bit_out_d;
   logic                       bit_valid_q, bit_valid_d;
   logic                       win_start_q, win_start_d;
   logic                       win_done_q, win_done_d;

   assign bus.inReady  = ~shadow_full_q;
   assign bus.bitOut   = bit_out_q;
   assign bus.bitValid = bit_valid_q;
   assign bus.winStart = win_start_q;
   assign bus.winDone  = win_done_q;

   // Shadow load, window sequencing and per-lane comparison
   always_comb begin
      state_d       = state_q;
      shadow_d      = shadow_q;
      active_d      = active_q;
      shadow_full_d = shadow_full_q;
      win_cnt_d     = win_cnt_q;
      bit_out_d     = '0;
      bit_valid_d   = 1'b0;
      win_start_d   = 1'b0;
      win_done_d    = 1'b0;

      if (bus.inValid && !shadow_full_q) begin
         shadow_d      = bus.inData;
         shadow_full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (shadow_full_q) begin
               active_d      = shadow_q;
               shadow_full_d = 1'b0;
               win_cnt_d     = '0;
               state_d       = RUN;
            end
         end
         RUN: begin
            if (bus.enable) begin
               for (int j = 0; j < SDIM; j++) begin
                  bit_out_d[j] = active_q[j] > bus.cntSeq[j];
               end
               bit_valid_d = 1'b1;
               win_start_d = (win_cnt_q == '0);
               win_done_d  = (win_cnt_q == LAST);
               win_cnt_d   = win_cnt_q + WW'(1);
               if (win_cnt_q == LAST) begin
                  win_cnt_d = '0;
                  // Swap straight into the next window when one is waiting
                  if (shadow_full_q) begin
                     active_d      = shadow_q;
                     shadow_full_d = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
      endcase
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         shadow_q      <= '0;
         active_q      <= '0;
         shadow_full_q <= 1'b0;
         win_cnt_q     <= '0;
         bit_out_q     <= '0;
         bit_valid_q   <= 1'b0;
         win_start_q   <= 1'b0;
         win_done_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         shadow_q      <= shadow_d;
         active_q      <= active_d;
         shadow_full_q <= shadow_full_d;
         win_cnt_q     <= win_cnt_d;
         bit_out_q     <= bit_out_d;
         bit_valid_q   <= bit_valid_d;
         win_start_q   <= win_start_d;
         win_done_q    <= win_done_d;
      end
   end
endmodule

// File: tb/tb_bsg_share_array32.sv
// Directed bench for bsg_share_array32 with CWID=4, WLEN=16
// and a modelled upstream counter advancing on enabled cycles.
module tb_bsg_share_array32;
   localparam int CW = 4;
   localparam int SD = 32;
   localparam int WL = 16;

   typedef logic [SD-1:0][CW-1:0] vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   cnt = 0;
   bit   toggle_en = 0;

   int   n_lead, n_valid, n_span, n_start, n_done;
   int   n_busy, n_junk, n_lane_bad;
   bit   first_start, last_ready, timed_out;
   int   ones [SD];

   bsg_share_array32_if #(.CWID(CW), .SDIM(SD)) bus ();

   bsg_share_array32 #(.CWID(CW), .SDIM(SD), .WLEN(WL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input int l0, input int l1,
                               input int l31, input int seed);
      vec_t v;
      for (int j = 0; j < SD; j++) v[j] = CW'((j * seed + 3) % WL);
      v[0]  = CW'(l0);
      v[1]  = CW'(l1);
      v[31] = CW'(l31);
      return v;
   endfunction

   task automatic drive_cnt();
      for (int j = 0; j < SD; j++) bus.cntSeq[j] = CW'((cnt + j) % WL);
   endtask

   task automatic tick();
      logic en;
      en = bus.enable;
      @(posedge clk);
      if (!rst_n) cnt = 0;
      else if (en) cnt = (cnt + 1) % WL;
      #1;
      if (toggle_en) bus.enable = ~bus.enable;
      drive_cnt();
   endtask

   // Gathers one window: leading idle samples, then up to winDone
   task automatic collect(input int budget, input bit clr, input vec_t exp);
      bit started, done;
      n_lead = 0; n_valid = 0; n_span = 0; n_start = 0; n_done = 0;
      n_busy = 0; n_junk = 0; n_lane_bad = 0;
      first_start = 0; last_ready = 0;
      started = 0; done = 0;
      for (int j = 0; j < SD; j++) ones[j] = 0;
      for (int c = 0; c < budget && !done; c++) begin
         tick();
         if (clr) bus.inValid = 1'b0;
         if (!started && !bus.bitValid) begin
            n_lead++;
            if (bus.bitOut !== '0) n_junk++;
            continue;
         end
         if (!started) first_start = bus.winStart;
         started = 1;
         n_span++;
         if (bus.bitValid) begin
            n_valid++;
            for (int j = 0; j < SD; j++) ones[j] += int'(bus.bitOut[j]);
            if (bus.winStart) n_start++;
            if (!bus.inReady) n_busy++;
            if (bus.winDone) begin
               n_done++;
               done = 1;
               last_ready = bus.inReady;
            end
         end else if (bus.bitOut !== '0 || bus.winStart || bus.winDone) begin
            n_junk++;
         end
      end
      timed_out = !done;
      for (int j = 0; j < SD; j++) if (ones[j] != int'(exp[j])) n_lane_bad++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.inValid = 1'b1;
      bus.inData = mk(9, 9, 9, 5);
      bus.enable = 1'b1;
      tick();
      tick();
      checks++; if (bus.bitOut !== '0) begin errors++;
         $display("FAIL rst_bitout: got %h want 0", bus.bitOut); end
      checks++; if (bus.bitValid !== 1'b0) begin errors++;
         $display("FAIL rst_bitvalid: got %b want 0", bus.bitValid); end
      checks++; if (bus.winStart !== 1'b0 || bus.winDone !== 1'b0) begin errors++;
         $display("FAIL rst_pulses: got %b%b want 00", bus.winStart, bus.winDone); end
      checks++; if (bus.inReady !== 1'b1) begin errors++;
         $display("FAIL rst_inready: got %b want 1", bus.inReady); end
      bus.inValid = 1'b0;
      rst_n = 1'b1;
      tick();
      tick();
      checks++; if (bus.inReady !== 1'b1) begin errors++;
         $display("FAIL rst_noload: inReady got %b want 1", bus.inReady); end
      checks++; if (bus.bitValid !== 1'b0) begin errors++;
         $display("FAIL rst_idle: bitValid got %b want 0", bus.bitValid); end
   endtask

   task automatic test_single_window();
      vec_t a;
      a = mk(5, 0, 15, 3);
      bus.inData = a;
      bus.inValid = 1'b1;
      bus.enable = 1'b1;
      collect(60, 1, a);
      checks++; if (timed_out) begin errors++;
         $display("FAIL sw_timeout: no winDone within budget"); end
      checks++; if (n_lead != 2) begin errors++;
         $display("FAIL sw_latency: got %0d want 2", n_lead); end
      checks++; if (n_valid != 16 || n_span != 16) begin errors++;
         $display("FAIL sw_len: got %0d/%0d want 16/16", n_valid, n_span); end
      checks++; if (ones[0] != 5 || ones[1] != 0 || ones[31] != 15) begin errors++;
         $display("FAIL sw_ones: got %0d/%0d/%0d want 5/0/15",
                  ones[0], ones[1], ones[31]); end
      checks++; if (n_lane_bad != 0) begin errors++;
         $display("FAIL sw_lanes: got %0d bad lanes want 0", n_lane_bad); end
      checks++; if (!first_start || n_start != 1 || n_done != 1) begin errors++;
         $display("FAIL sw_pulses: got %0d/%0d/%0d want 1/1/1",
                  first_start, n_start, n_done); end
      checks++; if (n_junk != 0) begin errors++;
         $display("FAIL sw_junk: got %0d want 0", n_junk); end
      tick();
      checks++; if (bus.bitValid !== 1'b0 || bus.winDone !== 1'b0) begin errors++;
         $display("FAIL sw_after: got %b%b want 00", bus.bitValid, bus.winDone); end
      tick();
      checks++; if (bus.bitValid !== 1'b0) begin errors++;
         $display("FAIL sw_idle: got %b want 0", bus.bitValid); end
   endtask

   task automatic test_back_to_back();
      vec_t a, b, c;
      a = mk(9, 2, 14, 5);
      b = mk(15, 7, 0, 7);
      c = mk(3, 12, 6, 11);
      bus.inData = a;
      bus.inValid = 1'b1;
      bus.enable = 1'b1;
      tick();
      bus.inValid = 1'b0;
      tick();
      repeat (4) tick();
      bus.inData = b;
      bus.inValid = 1'b1;
      checks++; if (bus.inReady !== 1'b1) begin errors++;
         $display("FAIL b2b_ready_pre: got %b want 1", bus.inReady); end
      tick();
      checks++; if (bus.inReady !== 1'b0) begin errors++;
         $display("FAIL b2b_ready_full: got %b want 0", bus.inReady); end
      bus.inData = c;
      collect(40, 0, a);
      checks++; if (timed_out || n_lead != 0 || n_valid != 11) begin errors++;
         $display("FAIL b2b_rest_a: got to=%0d lead=%0d n=%0d want 0/0/11",
                  timed_out, n_lead, n_valid); end
      checks++; if (n_busy != 10 || !last_ready) begin errors++;
         $display("FAIL b2b_busy_a: got %0d/%0d want 10/1", n_busy, last_ready); end
      collect(40, 1, b);
      checks++; if (timed_out || n_lead != 0 || !first_start) begin errors++;
         $display("FAIL b2b_nogap: got to=%0d lead=%0d st=%0d want 0/0/1",
                  timed_out, n_lead, first_start); end
      checks++; if (n_valid != 16 || n_lane_bad != 0 || ones[0] != 15) begin errors++;
         $display("FAIL b2b_win_b: got n=%0d bad=%0d l0=%0d want 16/0/15",
                  n_valid, n_lane_bad, ones[0]); end
      checks++; if (n_busy != 15 || !last_ready) begin errors++;
         $display("FAIL b2b_busy_b: got %0d/%0d want 15/1", n_busy, last_ready); end
      collect(40, 0, c);
      checks++; if (timed_out || n_lead != 0 || n_valid != 16 || n_lane_bad != 0) begin
         errors++;
         $display("FAIL b2b_win_c: got to=%0d lead=%0d n=%0d bad=%0d want 0/0/16/0",
                  timed_out, n_lead, n_valid, n_lane_bad); end
      tick();
      checks++; if (bus.bitValid !== 1'b0) begin errors++;
         $display("FAIL b2b_idle: got %b want 0", bus.bitValid); end
   endtask

   task automatic test_enable_toggle();
      vec_t d;
      d = mk(7, 1, 11, 9);
      bus.inData = d;
      bus.inValid = 1'b1;
      bus.enable = 1'b1;
      toggle_en = 1;
      collect(80, 1, d);
      toggle_en = 0;
      bus.enable = 1'b1;
      checks++; if (timed_out || n_valid != 16 || n_span != 31) begin errors++;
         $display("FAIL tog_len: got to=%0d n=%0d span=%0d want 0/16/31",
                  timed_out, n_valid, n_span); end
      checks++; if (n_lane_bad != 0 || ones[0] != 7 || ones[31] != 11) begin errors++;
         $display("FAIL tog_ones: got bad=%0d l0=%0d l31=%0d want 0/7/11",
                  n_lane_bad, ones[0], ones[31]); end
      checks++; if (n_junk != 0) begin errors++;
         $display("FAIL tog_gaps: got %0d junk samples want 0", n_junk); end
      tick();
      checks++; if (bus.bitValid !== 1'b0) begin errors++;
         $display("FAIL tog_idle: got %b want 0", bus.bitValid); end
   endtask

   task automatic test_load_on_done();
      vec_t e, f;
      e = mk(4, 8, 2, 13);
      f = mk(10, 3, 12, 15);
      bus.inData = e;
      bus.inValid = 1'b1;
      bus.enable = 1'b1;
      tick();
      bus.inValid = 1'b0;
      repeat (16) tick();
      checks++; if (bus.bitValid !== 1'b1 || bus.winDone !== 1'b0) begin errors++;
         $display("FAIL lod_pre: got %b%b want 10", bus.bitValid, bus.winDone); end
      bus.inData = f;
      bus.inValid = 1'b1;
      tick();
      checks++; if (bus.winDone !== 1'b1 || bus.inReady !== 1'b0) begin errors++;
         $display("FAIL lod_done: got done=%b rdy=%b want 1/0",
                  bus.winDone, bus.inReady); end
      bus.inValid = 1'b0;
      tick();
      checks++; if (bus.bitValid !== 1'b0) begin errors++;
         $display("FAIL lod_bubble: got %b want 0", bus.bitValid); end
      tick();
      checks++; if (bus.bitValid !== 1'b1 || bus.winStart !== 1'b1) begin errors++;
         $display("FAIL lod_start: got %b%b want 11", bus.bitValid, bus.winStart); end
      collect(40, 0, f);
      checks++; if (timed_out || n_valid != 15) begin errors++;
         $display("FAIL lod_rest: got to=%0d n=%0d want 0/15", timed_out, n_valid); end
   endtask

   task automatic test_reset_mid();
      vec_t g, h;
      g = mk(12, 6, 9, 17);
      h = mk(2, 2, 2, 19);
      bus.inData = g;
      bus.inValid = 1'b1;
      bus.enable = 1'b1;
      tick();
      bus.inData = h;
      tick();
      tick();
      bus.inValid = 1'b0;
      repeat (6) tick();
      checks++; if (bus.inReady !== 1'b0 || bus.bitValid !== 1'b1) begin errors++;
         $display("FAIL rm_pre: got rdy=%b v=%b want 0/1", bus.inReady, bus.bitValid); end
      rst_n = 1'b0;
      tick();
      checks++; if (bus.bitOut !== '0 || bus.bitValid !== 1'b0) begin errors++;
         $display("FAIL rm_out: got %h/%b want 0/0", bus.bitOut, bus.bitValid); end
      checks++; if (bus.winStart !== 1'b0 || bus.winDone !== 1'b0) begin errors++;
         $display("FAIL rm_pulses: got %b%b want 00", bus.winStart, bus.winDone); end
      checks++; if (bus.inReady !== 1'b1) begin errors++;
         $display("FAIL rm_ready: got %b want 1", bus.inReady); end
      rst_n = 1'b1;
      tick();
      tick();
      checks++; if (bus.bitValid !== 1'b0 || bus.inReady !== 1'b1) begin errors++;
         $display("FAIL rm_idle: got v=%b rdy=%b want 0/1", bus.bitValid, bus.inReady); end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.enable = 1'b0;
      bus.inValid = 1'b0;
      bus.inData = '0;
      drive_cnt();
      test_reset();
      test_single_window();
      test_back_to_back();
      test_enable_toggle();
      test_load_on_done();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
